// File: rtl/hazard_ctrl_if.sv
// Hazard controller handshake bundle between the pipeline ID/MEM stages and hazard_ctrl.
// Latency: none, plain wires. Backpressure: stall/bubble/flush flow back to the pipeline.
// Ports: id_* describe the ID instruction, br_taken comes from MEM; fwd_a/fwd_b, stall, bubble,
//        flush and stall_count are the controller's responses.
interface hazard_ctrl_if #(
  parameter int RA_W  = 2,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_uses_rs;
  logic            id_uses_rt;
  logic [RA_W-1:0] id_rd;
  logic            id_wr;
  logic            id_ld;
  logic            br_taken;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            stall;
  logic            bubble;
  logic            flush;
  logic [CNT_W-1:0] stall_count;

  // Pipeline side
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_wr, id_ld, br_taken,
    input  fwd_a, fwd_b, stall, bubble, flush, stall_count
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_wr, id_ld, br_taken,
    output fwd_a, fwd_b, stall, bubble, flush, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: shadow EX/MEM/WB destinations, load-use stall, branch flush.
// Latency: stall/bubble/flush combinational same cycle; fwd_a/fwd_b registered, valid in the EX cycle.
// Backpressure: stall holds PC and IF/ID; flush outranks stall; both insert a bubble into ID/EX.
// Ports: clock, reset (async, active-high), hif (slave side of hazard_ctrl_if).
module hazard_ctrl #(
  parameter int RA_W        = 2,
  parameter int ZERO_REG    = 0,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            wr;
    logic            ld;
  } slot_t;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [2:0] FLOAD = 3'(FLUSH_DEPTH - 1);

  slot_t            s_ex, s_mem, s_wb;
  state_t           state, state_n;
  logic [2:0]       fcnt, fcnt_n;
  logic [1:0]       fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] stall_cnt;

  logic br_in, flush_c, hazard, stall_c, bubble_c;
  logic a_ex, b_ex, a_mem, b_mem;

  function automatic logic hit(input slot_t s, input logic [RA_W-1:0] op, input logic uses);
    return s.valid && s.wr && (s.rd == op) && uses && !((ZERO_REG != 0) && (op == '0));
  endfunction

  // Branch pulse is ignored while reset is held so flush stays low.
  assign br_in = hif.br_taken & ~reset;

  assign a_ex  = hit(s_ex,  hif.id_rs, hif.id_uses_rs);
  assign b_ex  = hit(s_ex,  hif.id_rt, hif.id_uses_rt);
  assign a_mem = hit(s_mem, hif.id_rs, hif.id_uses_rs);
  assign b_mem = hit(s_mem, hif.id_rt, hif.id_uses_rt);

  assign hazard   = hif.id_valid & s_ex.ld & (a_ex | b_ex);
  assign flush_c  = br_in | (state == FLUSH);
  assign stall_c  = hazard & ~flush_c;
  assign bubble_c = stall_c | flush_c;

  // fcnt holds the FLUSH-state cycles still owed, counting the current one;
  // the branch cycle itself is the first flush cycle, so FLUSH lasts FLUSH_DEPTH-1 cycles.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    case (state)
      IDLE: begin
        if (br_in && (FLUSH_DEPTH > 1)) begin
          state_n = FLUSH;
          fcnt_n  = FLOAD;
        end
      end
      FLUSH: begin
        if (br_in) begin
          fcnt_n = FLOAD;
        end else if (fcnt <= 3'd1) begin
          state_n = IDLE;
          fcnt_n  = 3'd0;
        end else begin
          fcnt_n = fcnt - 3'd1;
        end
      end
      default: begin
        state_n = IDLE;
        fcnt_n  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      fcnt  <= 3'd0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_ex      <= '0;
      s_mem     <= '0;
      s_wb      <= '0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
      stall_cnt <= '0;
    end else begin
      s_wb  <= s_mem;
      s_mem <= s_ex;
      s_ex  <= bubble_c ? slot_t'('0) : slot_t'({hif.id_valid, hif.id_rd, hif.id_wr, hif.id_ld});
      // A bubble heading into EX needs no forwarding; otherwise the hazard is known absent here.
      if (bubble_c) begin
        fwd_a_q <= 2'b00;
        fwd_b_q <= 2'b00;
      end else begin
        fwd_a_q <= a_ex ? 2'b01 : (a_mem ? 2'b10 : 2'b00);
        fwd_b_q <= b_ex ? 2'b01 : (b_mem ? 2'b10 : 2'b00);
      end
      if (stall_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign hif.fwd_a       = fwd_a_q;
  assign hif.fwd_b       = fwd_b_q;
  assign hif.stall       = stall_c;
  assign hif.bubble      = bubble_c;
  assign hif.flush       = flush_c;
  assign hif.stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: u0 uses default parameters, u1 uses ZERO_REG=1,
// FLUSH_DEPTH=3, CNT_W=2; both see identical stimulus.
module tb_hazard_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       v, urs, urt, wr, ld, br;
  logic [1:0] rs, rt, rd;
  int checks = 0;
  int fails  = 0;

  hazard_ctrl_if #(.RA_W(2), .CNT_W(16)) h0 ();
  hazard_ctrl_if #(.RA_W(2), .CNT_W(2))  h1 ();

  assign h0.id_valid = v;   assign h1.id_valid = v;
  assign h0.id_rs = rs;     assign h1.id_rs = rs;
  assign h0.id_rt = rt;     assign h1.id_rt = rt;
  assign h0.id_uses_rs = urs; assign h1.id_uses_rs = urs;
  assign h0.id_uses_rt = urt; assign h1.id_uses_rt = urt;
  assign h0.id_rd = rd;     assign h1.id_rd = rd;
  assign h0.id_wr = wr;     assign h1.id_wr = wr;
  assign h0.id_ld = ld;     assign h1.id_ld = ld;
  assign h0.br_taken = br;  assign h1.br_taken = br;

  hazard_ctrl #(.RA_W(2), .ZERO_REG(0), .FLUSH_DEPTH(1), .CNT_W(16))
    u0 (.clock(clock), .reset(reset), .hif(h0.slave));
  hazard_ctrl #(.RA_W(2), .ZERO_REG(1), .FLUSH_DEPTH(3), .CNT_W(2))
    u1 (.clock(clock), .reset(reset), .hif(h1.slave));

  task automatic set_id(input logic iv, input logic [1:0] irs, input logic [1:0] irt,
                        input logic iurs, input logic iurt, input logic [1:0] ird,
                        input logic iwr, input logic ild);
    v = iv; rs = irs; rt = irt; urs = iurs; urt = iurt; rd = ird; wr = iwr; ld = ild;
  endtask

  task automatic nop();
    set_id(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    nop();
    br = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    br = 1'b1;
    set_id(1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1);
    #12;
    checks++; if (h0.fwd_a !== 2'b00) begin $display("FAIL rst_fwd_a: got %b exp 00", h0.fwd_a); fails++; end
    checks++; if (h0.fwd_b !== 2'b00) begin $display("FAIL rst_fwd_b: got %b exp 00", h0.fwd_b); fails++; end
    checks++; if (h0.stall !== 1'b0) begin $display("FAIL rst_stall: got %b exp 0", h0.stall); fails++; end
    checks++; if (h0.bubble !== 1'b0) begin $display("FAIL rst_bubble: got %b exp 0", h0.bubble); fails++; end
    checks++; if (h0.flush !== 1'b0) begin $display("FAIL rst_flush0: got %b exp 0", h0.flush); fails++; end
    checks++; if (h1.flush !== 1'b0) begin $display("FAIL rst_flush1: got %b exp 0", h1.flush); fails++; end
    checks++; if (h0.stall_count !== 16'd0) begin $display("FAIL rst_cnt0: got %0d exp 0", h0.stall_count); fails++; end
    checks++; if (h1.stall_count !== 2'd0) begin $display("FAIL rst_cnt1: got %0d exp 0", h1.stall_count); fails++; end
    br = 1'b0;
    nop();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_fwd_ex();
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0); cyc();
    set_id(1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0); #1;
    checks++; if (h0.stall !== 1'b0) begin $display("FAIL fex_stall: got %b exp 0", h0.stall); fails++; end
    cyc(); nop();
    checks++; if (h0.fwd_a !== 2'b01) begin $display("FAIL fex_a0: got %b exp 01", h0.fwd_a); fails++; end
    checks++; if (h0.fwd_b !== 2'b00) begin $display("FAIL fex_b0: got %b exp 00", h0.fwd_b); fails++; end
    checks++; if (h1.fwd_a !== 2'b01) begin $display("FAIL fex_a1: got %b exp 01", h1.fwd_a); fails++; end
    drain();
  endtask

  task automatic test_fwd_mem();
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0); cyc();
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0); cyc();
    set_id(1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0); cyc(); nop();
    checks++; if (h0.fwd_a !== 2'b10) begin $display("FAIL fmem_a: got %b exp 10", h0.fwd_a); fails++; end
    checks++; if (h0.fwd_b !== 2'b00) begin $display("FAIL fmem_b: got %b exp 00", h0.fwd_b); fails++; end
    drain();
  endtask

  task automatic test_fwd_priority();
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0); cyc();
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0); cyc();
    // rt names r1 but is not read, so only rs forwards
    set_id(1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0); cyc(); nop();
    checks++; if (h0.fwd_a !== 2'b01) begin $display("FAIL prio_a: got %b exp 01", h0.fwd_a); fails++; end
    checks++; if (h0.fwd_b !== 2'b00) begin $display("FAIL prio_unused_b: got %b exp 00", h0.fwd_b); fails++; end
    drain();
    // producer without register write never forwards
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0); cyc();
    set_id(1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0); cyc(); nop();
    checks++; if (h0.fwd_b !== 2'b00) begin $display("FAIL nowr_b: got %b exp 00", h0.fwd_b); fails++; end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1); cyc();
    set_id(1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0); #1;
    checks++; if (h0.stall !== 1'b1) begin $display("FAIL lu_stall: got %b exp 1", h0.stall); fails++; end
    checks++; if (h0.bubble !== 1'b1) begin $display("FAIL lu_bubble: got %b exp 1", h0.bubble); fails++; end
    checks++; if (h0.flush !== 1'b0) begin $display("FAIL lu_flush: got %b exp 0", h0.flush); fails++; end
    checks++; if (h0.stall_count !== 16'd0) begin $display("FAIL lu_cnt_pre: got %0d exp 0", h0.stall_count); fails++; end
    cyc();
    checks++; if (h0.stall !== 1'b0) begin $display("FAIL lu_stall_clear: got %b exp 0", h0.stall); fails++; end
    checks++; if (h0.bubble !== 1'b0) begin $display("FAIL lu_bubble_clear: got %b exp 0", h0.bubble); fails++; end
    checks++; if (h0.stall_count !== 16'd1) begin $display("FAIL lu_cnt: got %0d exp 1", h0.stall_count); fails++; end
    checks++; if (h0.fwd_b !== 2'b00) begin $display("FAIL lu_bubble_fwd: got %b exp 00", h0.fwd_b); fails++; end
    cyc(); nop();
    checks++; if (h0.fwd_b !== 2'b10) begin $display("FAIL lu_fwd_b: got %b exp 10", h0.fwd_b); fails++; end
    checks++; if (h0.fwd_a !== 2'b00) begin $display("FAIL lu_fwd_a: got %b exp 00", h0.fwd_a); fails++; end
    drain();
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1); cyc();
    set_id(1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1); #1;
    checks++; if (h0.stall !== 1'b1) begin $display("FAIL b2b_stall1: got %b exp 1", h0.stall); fails++; end
    cyc();
    checks++; if (h0.stall !== 1'b0) begin $display("FAIL b2b_gap1: got %b exp 0", h0.stall); fails++; end
    cyc();
    set_id(1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0); #1;
    checks++; if (h0.stall !== 1'b1) begin $display("FAIL b2b_stall2: got %b exp 1", h0.stall); fails++; end
    checks++; if (h0.fwd_a !== 2'b10) begin $display("FAIL b2b_ld2_fwd_a: got %b exp 10", h0.fwd_a); fails++; end
    cyc();
    checks++; if (h0.stall !== 1'b0) begin $display("FAIL b2b_gap2: got %b exp 0", h0.stall); fails++; end
    checks++; if (h0.stall_count !== 16'd3) begin $display("FAIL b2b_cnt0: got %0d exp 3", h0.stall_count); fails++; end
    checks++; if (h1.stall_count !== 2'd3) begin $display("FAIL b2b_cnt1: got %0d exp 3", h1.stall_count); fails++; end
    cyc(); nop();
    checks++; if (h0.fwd_b !== 2'b10) begin $display("FAIL b2b_fwd_b: got %b exp 10", h0.fwd_b); fails++; end
    drain();
  endtask

  task automatic test_zero_reg();
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0); cyc();
    set_id(1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0); cyc(); nop();
    checks++; if (h1.fwd_a !== 2'b00) begin $display("FAIL zr_a1: got %b exp 00", h1.fwd_a); fails++; end
    checks++; if (h1.fwd_b !== 2'b00) begin $display("FAIL zr_b1: got %b exp 00", h1.fwd_b); fails++; end
    checks++; if (h0.fwd_a !== 2'b01) begin $display("FAIL zr_a0: got %b exp 01", h0.fwd_a); fails++; end
    checks++; if (h0.fwd_b !== 2'b01) begin $display("FAIL zr_b0: got %b exp 01", h0.fwd_b); fails++; end
    drain();
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1); cyc();
    set_id(1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0); #1;
    checks++; if (h1.stall !== 1'b0) begin $display("FAIL zr_stall1: got %b exp 0", h1.stall); fails++; end
    checks++; if (h0.stall !== 1'b1) begin $display("FAIL zr_stall0: got %b exp 1", h0.stall); fails++; end
    cyc();
    drain();
  endtask

  task automatic test_flush();
    nop();
    br = 1'b1; #1;
    checks++; if (h1.flush !== 1'b1) begin $display("FAIL fl_c0: got %b exp 1", h1.flush); fails++; end
    checks++; if (h1.bubble !== 1'b1) begin $display("FAIL fl_c0_bub: got %b exp 1", h1.bubble); fails++; end
    checks++; if (h1.stall !== 1'b0) begin $display("FAIL fl_c0_stall: got %b exp 0", h1.stall); fails++; end
    checks++; if (h0.flush !== 1'b1) begin $display("FAIL fl_d1_c0: got %b exp 1", h0.flush); fails++; end
    cyc(); br = 1'b0; #1;
    checks++; if (h1.flush !== 1'b1) begin $display("FAIL fl_c1: got %b exp 1", h1.flush); fails++; end
    checks++; if (h1.bubble !== 1'b1) begin $display("FAIL fl_c1_bub: got %b exp 1", h1.bubble); fails++; end
    checks++; if (h0.flush !== 1'b0) begin $display("FAIL fl_d1_c1: got %b exp 0", h0.flush); fails++; end
    cyc();
    checks++; if (h1.flush !== 1'b1) begin $display("FAIL fl_c2: got %b exp 1", h1.flush); fails++; end
    checks++; if (h1.bubble !== 1'b1) begin $display("FAIL fl_c2_bub: got %b exp 1", h1.bubble); fails++; end
    cyc();
    checks++; if (h1.flush !== 1'b0) begin $display("FAIL fl_c3: got %b exp 0", h1.flush); fails++; end
    checks++; if (h1.bubble !== 1'b0) begin $display("FAIL fl_c3_bub: got %b exp 0", h1.bubble); fails++; end
    cyc();
    // second pulse lands in the second flush cycle and restarts the count
    br = 1'b1; cyc();
    br = 1'b1; #1;
    checks++; if (h1.flush !== 1'b1) begin $display("FAIL rfl_c1: got %b exp 1", h1.flush); fails++; end
    cyc(); br = 1'b0; #1;
    checks++; if (h1.flush !== 1'b1) begin $display("FAIL rfl_c2: got %b exp 1", h1.flush); fails++; end
    cyc();
    checks++; if (h1.flush !== 1'b1) begin $display("FAIL rfl_c3: got %b exp 1", h1.flush); fails++; end
    cyc();
    checks++; if (h1.flush !== 1'b0) begin $display("FAIL rfl_c4: got %b exp 0", h1.flush); fails++; end
    drain();
  endtask

  task automatic test_flush_beats_stall();
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0); cyc();
    set_id(1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0); br = 1'b1; cyc();
    br = 1'b0; nop();
    checks++; if (h0.fwd_a !== 2'b00) begin $display("FAIL flfwd_a0: got %b exp 00", h0.fwd_a); fails++; end
    checks++; if (h1.fwd_a !== 2'b00) begin $display("FAIL flfwd_a1: got %b exp 00", h1.fwd_a); fails++; end
    drain();
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1); cyc();
    set_id(1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0); br = 1'b1; #1;
    checks++; if (h0.flush !== 1'b1) begin $display("FAIL fbs_flush: got %b exp 1", h0.flush); fails++; end
    checks++; if (h0.stall !== 1'b0) begin $display("FAIL fbs_stall0: got %b exp 0", h0.stall); fails++; end
    checks++; if (h0.bubble !== 1'b1) begin $display("FAIL fbs_bubble: got %b exp 1", h0.bubble); fails++; end
    checks++; if (h1.stall !== 1'b0) begin $display("FAIL fbs_stall1: got %b exp 0", h1.stall); fails++; end
    cyc(); br = 1'b0; nop();
    checks++; if (h0.stall_count !== 16'd4) begin $display("FAIL fbs_cnt0: got %0d exp 4", h0.stall_count); fails++; end
    checks++; if (h1.stall_count !== 2'd3) begin $display("FAIL fbs_cnt1: got %0d exp 3", h1.stall_count); fails++; end
    drain();
  endtask

  task automatic test_reset_mid();
    br = 1'b1; cyc(); br = 1'b0; #1;
    checks++; if (h1.flush !== 1'b1) begin $display("FAIL rm_pre_flush: got %b exp 1", h1.flush); fails++; end
    reset = 1'b1; #1;
    checks++; if (h1.flush !== 1'b0) begin $display("FAIL rm_flush: got %b exp 0", h1.flush); fails++; end
    checks++; if (h1.bubble !== 1'b0) begin $display("FAIL rm_bubble: got %b exp 0", h1.bubble); fails++; end
    checks++; if (h0.stall_count !== 16'd0) begin $display("FAIL rm_cnt0: got %0d exp 0", h0.stall_count); fails++; end
    checks++; if (h1.stall_count !== 2'd0) begin $display("FAIL rm_cnt1: got %0d exp 0", h1.stall_count); fails++; end
    cyc(); reset = 1'b0; #1;
    checks++; if (h1.flush !== 1'b0) begin $display("FAIL rm_idle0: got %b exp 0", h1.flush); fails++; end
    cyc();
    checks++; if (h1.flush !== 1'b0) begin $display("FAIL rm_idle1: got %b exp 0", h1.flush); fails++; end
    set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1); cyc();
    set_id(1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0); #1;
    checks++; if (h0.stall !== 1'b1) begin $display("FAIL rs_pre_stall: got %b exp 1", h0.stall); fails++; end
    reset = 1'b1; #1;
    checks++; if (h0.stall !== 1'b0) begin $display("FAIL rs_stall: got %b exp 0", h0.stall); fails++; end
    checks++; if (h0.bubble !== 1'b0) begin $display("FAIL rs_bubble: got %b exp 0", h0.bubble); fails++; end
    cyc(); reset = 1'b0;
    drain();
  endtask

  task automatic test_saturation();
    int exp0 [5] = '{1, 2, 3, 4, 5};
    int exp1 [5] = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1); cyc();
      set_id(1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0); cyc();
      cyc();
      checks++; if (int'(h0.stall_count) !== exp0[i]) begin $display("FAIL sat_cnt0[%0d]: got %0d exp %0d", i, h0.stall_count, exp0[i]); fails++; end
      checks++; if (int'(h1.stall_count) !== exp1[i]) begin $display("FAIL sat_cnt1[%0d]: got %0d exp %0d", i, h1.stall_count, exp1[i]); fails++; end
    end
    drain();
  endtask

  initial begin
    br = 1'b0;
    nop();
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_fwd_priority();
    test_load_use();
    test_back_to_back();
    test_zero_reg();
    test_flush();
    test_flush_beats_stall();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end
endmodule
